// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package imem_loader_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 64;
  localparam int unsigned CNT_W               = 16;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned SHIFT_W             = 3 * BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // States in which the loader is willing to take a stream byte.
  function automatic logic takes_byte(loader_state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (no effect on this file).
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  // Host side: sources the byte stream and observes memory writes.
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four accepted payload bytes (LSB first) into one 32-bit word.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (no effect on this file).
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_done_c,
  output logic [WORD_W-1:0] wdata
);

  logic [SHIFT_W-1:0] shift_q;
  logic [1:0]         cnt_q;

  assign word_done_c = byte_en && (cnt_q == 2'd3);

  // Bytes shift in from the top so that after three bytes shift_q = {b2,b1,b0}.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      wdata   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en) begin
      cnt_q <= cnt_q + 2'd1;
      if (word_done_c) begin
        wdata <= {byte_in, shift_q};
      end else begin
        shift_q <= {byte_in, shift_q[SHIFT_W-1:BYTE_W]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted byte image, writes it to imem from 0x0 and
// releases the core from reset once complete. Macro IMEM_LOADER_CHECKSUM_EN
// adds a trailing XOR checksum byte that must match before release.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         restart,
  imem_loader_if.slave bus,
  output logic         core_reset,
  output logic         done,
  output logic         err
);

  loader_state_t     state_q, next_state;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  hdr_c;
  logic [BYTE_W-1:0] n_lo_q, n_lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic              done_d, err_d, core_reset_d;
  logic              accept_c, payload_byte_c, word_done_c, last_word_c;
  logic [WORD_W-1:0] wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  // restart suppresses consumption of any byte presented alongside it
  assign accept_c       = bus.rx_valid && rx_ready_q && !restart;
  assign payload_byte_c = accept_c && (state_q == ST_PAYLOAD);
  assign last_word_c    = word_done_c && (index_q == (n_q - CNT_W'(1)));
  assign hdr_c          = {bus.rx_data, n_lo_q};

  word_assembler u_word_assembler (
    .clk         (clk),
    .reset       (reset),
    .clear       (restart),
    .byte_en     (payload_byte_c),
    .byte_in     (bus.rx_data),
    .word_done_c (word_done_c),
    .wdata       (wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    index_d    = index_q;
    n_d        = n_q;
    n_lo_d     = n_lo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (restart) begin
      next_state = ST_CNT_LO;
      index_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: next_state = ST_CNT_LO;
        ST_CNT_LO: begin
          if (accept_c) begin
            n_lo_d     = bus.rx_data;
            next_state = ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (accept_c) begin
            n_d = hdr_c;
            if ((hdr_c == '0) || (32'(hdr_c) > DEPTH_WORDS)) begin
              next_state = ST_ERROR;
            end else begin
              next_state = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ bus.rx_data;
`endif
            if (word_done_c) begin
              index_d = index_q + CNT_W'(1);
            end
            if (last_word_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              next_state = ST_CHECK;
`else
              next_state = ST_DONE;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept_c) begin
            next_state = (bus.rx_data == csum_q) ? ST_DONE : ST_ERROR;
          end
        end
`endif
        default: next_state = state_q;
      endcase
    end

    // Registered outputs are computed from the state being entered.
    rx_ready_d   = !restart && takes_byte(next_state);
    we_d         = word_done_c;
    addr_d       = word_done_c ? ADDR_W'({index_q, 2'b00}) : addr_q;
    done_d       = (next_state == ST_DONE);
    err_d        = (next_state == ST_ERROR);
    core_reset_d = !((state_q == ST_DONE) && (next_state == ST_DONE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q    <= '0;
      n_q        <= '0;
      n_lo_q     <= '0;
      addr_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      index_q    <= index_d;
      n_q        <= n_d;
      n_lo_q     <= n_lo_d;
      addr_q     <= addr_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      done       <= done_d;
      err        <= err_d;
      core_reset <= core_reset_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN so the
// stream carries a checksum byte only when the feature is built in.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic restart;
  logic core_reset, done, err;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .bus        (bus),
    .core_reset (core_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  img [$];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Record every memory write strobe.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Header, up to two words LSB first, then XOR checksum (or a wrong 0x00).
  task automatic build_image(input logic [15:0] n, input logic [31:0] w0,
                             input logic [31:0] w1, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    img.delete();
    img.push_back(n[7:0]);
    img.push_back(n[15:8]);
    for (int i = 0; i < int'(n) && i < 2; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int b = 0; b < 4; b++) begin
        img.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(bad_csum ? 8'h00 : cs);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  // Present one byte and return just after the edge that consumes it.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_stream(input int cnt, input bit gaps);
    for (int i = 0; i < cnt; i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hA5;
      end
      send_byte(img[i]);
    end
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_core_reset_held"}, 32'(core_reset), 32'd1);
    check({tag, "_rx_ready_low"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    @(negedge clk);
    check({tag, "_core_reset_released"}, 32'(core_reset), 32'd0);
    @(negedge clk);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_rx_ready_low"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_core_reset_held"}, 32'(core_reset), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [31:0] w0, input logic [31:0] w1);
    check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
    if (n > 0 && wr_addr.size() > 0) begin
      check({tag, "_wr0_addr"}, wr_addr[0], 32'h0);
      check({tag, "_wr0_data"}, wr_data[0], w0);
    end
    if (n > 1 && wr_addr.size() > 1) begin
      check({tag, "_wr1_addr"}, wr_addr[1], 32'h4);
      check({tag, "_wr1_data"}, wr_data[1], w1);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_restart(input logic v, input logic [7:0] d);
    @(negedge clk);
    restart      = 1'b1;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(negedge clk);
    restart      = 1'b0;
    bus.rx_valid = 1'b0;
    check("restart_rx_ready_low", 32'(bus.rx_ready), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 32'h0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    restart      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clk);
    check("rx_ready_after_release", 32'(bus.rx_ready), 32'd1);

    // Two-word image, rx_valid held high; checksum is XOR of payload = 0x10.
    clear_writes();
    build_image(16'd2, 32'h0050_0113, 32'h00C0_0193, 1'b0);
    send_stream(img.size(), 1'b0);
    expect_done("load2");
    check_writes("load2", 2, 32'h0050_0113, 32'h00C0_0193);

    // Same image with idle cycles carrying junk data between bytes.
    pulse_restart(1'b0, 8'h00);
    clear_writes();
    send_stream(img.size(), 1'b1);
    expect_done("gaps");
    check_writes("gaps", 2, 32'h0050_0113, 32'h00C0_0193);

    // Illegal headers: zero words and one past capacity.
    pulse_restart(1'b0, 8'h00);
    clear_writes();
    build_image(16'd0, 32'h0, 32'h0, 1'b0);
    send_stream(2, 1'b0);
    expect_err("n0");
    check_writes("n0", 0, 32'h0, 32'h0);

    pulse_restart(1'b0, 8'h00);
    clear_writes();
    build_image(16'd65, 32'h0, 32'h0, 1'b0);
    send_stream(2, 1'b0);
    expect_err("n65");
    check_writes("n65", 0, 32'h0, 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Correct checksum would be 0x5A; 0x00 is sent instead.
    pulse_restart(1'b0, 8'h00);
    clear_writes();
    build_image(16'd1, 32'h0000_005A, 32'h0, 1'b1);
    send_stream(img.size(), 1'b0);
    expect_err("badcs");
    check_writes("badcs", 1, 32'h0000_005A, 32'h0);
`endif

    // Restart after three payload bytes, with a byte that must be dropped.
    pulse_restart(1'b0, 8'h00);
    clear_writes();
    build_image(16'd2, 32'h0050_0113, 32'h00C0_0193, 1'b0);
    send_stream(5, 1'b0);
    pulse_restart(1'b1, 8'hEE);
    check("restart_done_low", 32'(done), 32'd0);
    build_image(16'd1, 32'h0BAD_F00D, 32'h0, 1'b0);
    send_stream(img.size(), 1'b0);
    expect_done("rst_mid");
    check_writes("rst_mid", 1, 32'h0BAD_F00D, 32'h0);

    // Asynchronous reset while the first word is being written.
    pulse_restart(1'b0, 8'h00);
    build_image(16'd2, 32'h0050_0113, 32'h00C0_0193, 1'b0);
    send_stream(6, 1'b0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("pre_reset_we", 32'(bus.imem_we), 32'd1);
    check("pre_reset_wdata", bus.imem_wdata, 32'h0050_0113);
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    reset = 1'b1;
    clear_writes();
    send_stream(img.size(), 1'b0);
    expect_done("reload");
    check_writes("reload", 2, 32'h0050_0113, 32'h00C0_0193);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
